ecc_secded_scrub_memory: RTL and testbench

//  Parametrised SEC-DED (extended Hamming) protected single-clock memory with background scrubber.

---
 rtl/ecc_secded_scrub_memory_if.sv | 26 ++
 rtl/ecc_secded_scrub_memory.sv | 218 +++++++++++++++++++++
 tb/tb_ecc_secded_scrub_memory.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_secded_scrub_memory_if.sv
// Read/write bus of the SEC-DED scrubbed memory: the master issues requests
// and the slave (the memory) returns registered read results.
interface ecc_secded_scrub_memory_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_sec;
    logic              rd_ded;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_valid, rd_data, rd_sec, rd_ded
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_valid, rd_data, rd_sec, rd_ded
    );
endinterface

// File: rtl/ecc_secded_scrub_memory.sv
// Extended-Hamming (SEC-DED) protected memory with fault injection and a
// background scrubber that rewrites single-bit-corrupted words in idle cycles.
module ecc_secded_scrub_memory #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter int SCRUB_INTERVAL = 256,
    parameter int CNT_W          = 16,
    localparam int P             = $clog2(DATA_W + 1 + $clog2(DATA_W + 1)),
    localparam int CODE_W        = DATA_W + P + 1,
    localparam int BIT_W         = $clog2(CODE_W)
) (
    input  logic                         clk,
    input  logic                         rst,
    ecc_secded_scrub_memory_if.slave     bus,
    input  logic                         fault_inject,
    input  logic [ADDR_W-1:0]            fault_addr,
    input  logic [BIT_W-1:0]             fault_bit0,
    input  logic                         fault_double,
    input  logic [BIT_W-1:0]             fault_bit1,
    input  logic                         scrub_en,
    output logic                         scrub_busy,
    output logic                         scrub_done,
    output logic [CNT_W-1:0]             sec_count,
    output logic [CNT_W-1:0]             ded_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int IW    = $clog2(SCRUB_INTERVAL + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_CHECK, S_WB, S_NEXT} state_t;

    // Position 0 is overall parity, powers of two are Hamming parities, data fills the rest.
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c, sh;
        logic [DATA_W-1:0] dsh;
        logic par;
        int di;
        c  = '0;
        di = 0;
        for (int j = 1; j < CODE_W; j++) begin
            if ((j & (j - 1)) != 0) begin
                dsh = d >> di;
                c   = c | (CODE_W'(dsh[0]) << j);
                di++;
            end
        end
        for (int k = 0; k < P; k++) begin
            par = 1'b0;
            for (int j = 1; j < CODE_W; j++) begin
                if (((j >> k) & 1) == 1) begin
                    sh  = c >> j;
                    par = par ^ sh[0];
                end
            end
            c = c | (CODE_W'(par) << (1 << k));
        end
        return c | CODE_W'(^c);
    endfunction

    // Returns {ded, sec, data}; on DED the data bits are passed through raw.
    function automatic logic [DATA_W+1:0] decode(input logic [CODE_W-1:0] c);
        logic [P-1:0]      s;
        logic [CODE_W-1:0] fixed, sh;
        logic [DATA_W-1:0] d;
        logic              sec, ded;
        int                di;
        s = '0;
        for (int j = 1; j < CODE_W; j++) begin
            sh = c >> j;
            if (sh[0]) s = s ^ P'(j);
        end
        fixed = c;
        sec   = 1'b0;
        ded   = 1'b0;
        if (s != '0 && (^c)) begin
            if ({1'b0, s} < (P+1)'(CODE_W)) begin
                fixed = c ^ (CODE_W'(1) << s);
                sec   = 1'b1;
            end else begin
                ded = 1'b1;
            end
        end else if (^c) begin
            sec = 1'b1;
        end else if (s != '0) begin
            ded = 1'b1;
        end
        d  = '0;
        di = 0;
        for (int j = 1; j < CODE_W; j++) begin
            if ((j & (j - 1)) != 0) begin
                sh = fixed >> j;
                d  = d | (DATA_W'(sh[0]) << di);
                di++;
            end
        end
        return {ded, sec, d};
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, c} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    logic [CODE_W-1:0] mem [DEPTH];
    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [IW-1:0]     interval_reg;
    logic [CODE_W-1:0] scrub_word_reg;
    logic              cancel_reg;
    logic              rd_valid_reg, rd_sec_reg, rd_ded_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [CNT_W-1:0]  sec_count_reg, ded_count_reg;

    logic [DATA_W+1:0] rd_dec, scrub_dec;
    logic [CODE_W-1:0] fault_mask;
    logic              bus_busy, inject_ok, ptr_hit, cancel_now;
    logic              scrub_capture, scrub_write, scrub_check;
    logic [1:0]        sec_inc, ded_inc;

    assign rd_dec     = decode(mem[bus.rd_addr]);
    assign scrub_dec  = decode(scrub_word_reg);
    assign bus_busy   = bus.wr_en | fault_inject | bus.rd_en;
    assign inject_ok  = fault_inject && !(bus.wr_en && bus.wr_addr == fault_addr);
    assign ptr_hit    = (bus.wr_en && bus.wr_addr == ptr_reg) || (fault_inject && fault_addr == ptr_reg);
    assign cancel_now = cancel_reg | ptr_hit;

    always_comb begin
        fault_mask = '0;
        if ({1'b0, fault_bit0} < (BIT_W+1)'(CODE_W))
            fault_mask = fault_mask | (CODE_W'(1) << fault_bit0);
        if (fault_double && ({1'b0, fault_bit1} < (BIT_W+1)'(CODE_W)))
            fault_mask = fault_mask | (CODE_W'(1) << fault_bit1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (scrub_en) state_next = S_WAIT;
            S_WAIT:  if (!scrub_en) state_next = S_IDLE;
                     else if (interval_reg == IW'(SCRUB_INTERVAL - 1)) state_next = S_READ;
            S_READ:  if (!bus_busy) state_next = S_CHECK;
            S_CHECK: state_next = (scrub_dec[DATA_W] && !cancel_now) ? S_WB : S_NEXT;
            S_WB:    if (cancel_now || !bus_busy) state_next = S_NEXT;
            S_NEXT:  state_next = scrub_en ? S_WAIT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        scrub_capture = (state_reg == S_READ) && !bus_busy;
        scrub_write   = (state_reg == S_WB) && !cancel_now && !bus_busy;
        scrub_check   = (state_reg == S_CHECK);
        scrub_busy    = (state_reg == S_READ) || (state_reg == S_CHECK) ||
                        (state_reg == S_WB)   || (state_reg == S_NEXT);
        scrub_done    = (state_reg == S_NEXT) && (ptr_reg == ADDR_W'(DEPTH - 1));
    end

    // A write or injection hitting the word under scrub makes the captured copy stale.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_reg        <= '0;
            interval_reg   <= '0;
            scrub_word_reg <= '0;
            cancel_reg     <= 1'b0;
        end else begin
            interval_reg <= (state_reg == S_WAIT && state_next == S_WAIT) ? interval_reg + 1'b1 : '0;
            if (scrub_capture) scrub_word_reg <= mem[ptr_reg];
            cancel_reg <= (state_reg == S_CHECK || state_reg == S_WB) ? cancel_now : 1'b0;
            if (state_reg == S_NEXT) ptr_reg <= ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (scrub_write) mem[ptr_reg] <= encode(scrub_dec[DATA_W-1:0]);
            if (inject_ok)   mem[fault_addr] <= mem[fault_addr] ^ fault_mask;
            if (bus.wr_en)   mem[bus.wr_addr] <= encode(bus.wr_data);
        end
    end

    assign sec_inc = {1'b0, bus.rd_en & rd_dec[DATA_W]}   + {1'b0, scrub_check & scrub_dec[DATA_W]};
    assign ded_inc = {1'b0, bus.rd_en & rd_dec[DATA_W+1]} + {1'b0, scrub_check & scrub_dec[DATA_W+1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_reg  <= 1'b0;
            rd_data_reg   <= '0;
            rd_sec_reg    <= 1'b0;
            rd_ded_reg    <= 1'b0;
            sec_count_reg <= '0;
            ded_count_reg <= '0;
        end else begin
            rd_valid_reg <= bus.rd_en;
            rd_sec_reg   <= bus.rd_en & rd_dec[DATA_W];
            rd_ded_reg   <= bus.rd_en & rd_dec[DATA_W+1];
            if (bus.rd_en) rd_data_reg <= rd_dec[DATA_W-1:0];
            sec_count_reg <= sat_add(sec_count_reg, sec_inc);
            ded_count_reg <= sat_add(ded_count_reg, ded_inc);
        end
    end

    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_sec   = rd_sec_reg;
    assign bus.rd_ded   = rd_ded_reg;
    assign sec_count    = sec_count_reg;
    assign ded_count    = ded_count_reg;
endmodule

// File: tb/tb_ecc_secded_scrub_memory.sv
// Bench for the SEC-DED scrubbed memory: a per-word data/flip-mask model predicts
// read results and error counters, checked every cycle, plus literal expectations.
module tb_ecc_secded_scrub_memory;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int CODE_W = 13;
    localparam int CMAX   = 65535;
    localparam int DPOS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ecc_secded_scrub_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    logic              fault_inject, fault_double, scrub_en;
    logic [ADDR_W-1:0] fault_addr;
    logic [3:0]        fault_bit0, fault_bit1;
    logic              scrub_busy, scrub_done;
    logic [15:0]       sec_count, ded_count;

    ecc_secded_scrub_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCRUB_INTERVAL(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .fault_inject(fault_inject), .fault_addr(fault_addr), .fault_bit0(fault_bit0),
        .fault_double(fault_double), .fault_bit1(fault_bit1), .scrub_en(scrub_en),
        .scrub_busy(scrub_busy), .scrub_done(scrub_done),
        .sec_count(sec_count), .ded_count(ded_count)
    );

    logic [7:0]  m_data [DEPTH];
    logic [12:0] m_mask [DEPTH];
    int          m_sec = 0, m_ded = 0;
    logic        e_valid = 1'b0, e_sec = 1'b0, e_ded = 1'b0;
    logic [7:0]  e_data = 8'h00;
    int          checks = 0, fails = 0;
    bit          check_on = 0, scrub_active = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Zero flips: clean; one flip anywhere: corrected; two flips: detected, data bits raw.
    function automatic logic [9:0] expect_word(input logic [7:0] d, input logic [12:0] mask);
        logic [7:0] raw;
        int n;
        raw = d;
        n   = $countones(mask);
        for (int i = 0; i < 8; i++) if (mask[DPOS[i][3:0]]) raw[i] = ~raw[i];
        if (n == 0) return {2'b00, d};
        if (n == 1) return {2'b01, d};
        return {2'b10, raw};
    endfunction

    always @(posedge clk) begin
        logic [9:0] r;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_data[i] = '0;
                m_mask[i] = '0;
            end
            m_sec = 0; m_ded = 0;
            e_valid = 0; e_sec = 0; e_ded = 0; e_data = '0;
        end else begin
            e_valid = bus.rd_en;
            e_sec = 0; e_ded = 0;
            if (bus.rd_en) begin
                r = expect_word(m_data[bus.rd_addr], m_mask[bus.rd_addr]);
                e_data = r[7:0]; e_sec = r[8]; e_ded = r[9];
                if (e_sec && m_sec < CMAX) m_sec++;
                if (e_ded && m_ded < CMAX) m_ded++;
            end
            if (fault_inject && !(bus.wr_en && bus.wr_addr == fault_addr)) begin
                if (fault_bit0 < CODE_W) m_mask[fault_addr] = m_mask[fault_addr] ^ (13'(1) << fault_bit0);
                if (fault_double && fault_bit1 < CODE_W)
                    m_mask[fault_addr] = m_mask[fault_addr] ^ (13'(1) << fault_bit1);
            end
            if (bus.wr_en) begin
                m_data[bus.wr_addr] = bus.wr_data;
                m_mask[bus.wr_addr] = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            chk("rd_valid", bus.rd_valid, e_valid);
            if (e_valid) begin
                chk("rd_data", bus.rd_data, e_data);
                chk("rd_sec", bus.rd_sec, e_sec);
                chk("rd_ded", bus.rd_ded, e_ded);
            end
            if (!scrub_active) begin
                chk("sec_count", sec_count, m_sec);
                chk("ded_count", ded_count, m_ded);
                chk("scrub_busy idle", scrub_busy, 1'b0);
                chk("scrub_done idle", scrub_done, 1'b0);
            end
        end
    end

    // A full sweep with no traffic corrects every single-flip word and counts each double once.
    task automatic apply_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            if ($countones(m_mask[i]) == 1) begin
                if (m_sec < CMAX) m_sec++;
                m_mask[i] = '0;
            end else if ($countones(m_mask[i]) == 2) begin
                if (m_ded < CMAX) m_ded++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 0;
        $display("write @%0d data %02h", a, d);
    endtask

    task automatic inj(input logic [3:0] a, input logic [3:0] b0, input logic dbl, input logic [3:0] b1);
        fault_inject = 1; fault_addr = a; fault_bit0 = b0; fault_double = dbl; fault_bit1 = b1;
        step();
        fault_inject = 0; fault_double = 0;
        $display("inject @%0d bit %0d double %0b bit %0d", a, b0, dbl, b1);
    endtask

    task automatic rd(input logic [3:0] a);
        bus.rd_en = 1; bus.rd_addr = a;
        step();
        bus.rd_en = 0;
        @(negedge clk);
        $display("read @%0d -> data %02h sec %0b ded %0b", a, bus.rd_data, bus.rd_sec, bus.rd_ded);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  busy_seen;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_en = 0; bus.rd_addr = '0;
        fault_inject = 0; fault_addr = '0; fault_bit0 = '0; fault_double = 0; fault_bit1 = '0;
        scrub_en = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        check_on = 1;
        @(negedge clk);
        chk("reset rd_valid", bus.rd_valid, 1'b0);
        chk("reset sec_count", sec_count, 16'h0);

        wr(3, 8'hA5); rd(3);
        chk("A5 valid", bus.rd_valid, 1'b1);
        chk("A5 data", bus.rd_data, 8'hA5);
        chk("A5 sec", bus.rd_sec, 1'b0);
        chk("A5 ded", bus.rd_ded, 1'b0);

        wr(5, 8'h3C); inj(5, 6, 0, 0); rd(5);
        chk("sec data", bus.rd_data, 8'h3C);
        chk("sec flag", bus.rd_sec, 1'b1);
        chk("sec_count one", sec_count, 16'd1);

        wr(5, 8'h3C); inj(5, 2, 1, 9); rd(5);
        chk("ded flag", bus.rd_ded, 1'b1);
        chk("ded no sec", bus.rd_sec, 1'b0);
        chk("ded raw data", bus.rd_data, 8'h2C);
        chk("ded_count one", ded_count, 16'd1);

        bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 8'h11; bus.rd_en = 1; bus.rd_addr = 3;
        step();
        bus.wr_en = 0; bus.rd_en = 0;
        @(negedge clk);
        $display("read+write @3 -> data %02h", bus.rd_data);
        chk("read-before-write", bus.rd_data, 8'hA5);
        rd(3);
        chk("new data", bus.rd_data, 8'h11);

        bus.wr_en = 1; bus.wr_addr = 8; bus.wr_data = 8'h77;
        fault_inject = 1; fault_addr = 8; fault_bit0 = 5;
        step();
        bus.wr_en = 0; fault_inject = 0;
        rd(8);
        chk("write beats inject", bus.rd_sec, 1'b0);
        inj(8, 14, 0, 0); rd(8);
        chk("index >= CODE_W ignored", bus.rd_sec, 1'b0);
        inj(8, 3, 1, 15); rd(8);
        chk("second index ignored", bus.rd_sec, 1'b1);
        inj(10, 0, 0, 0); rd(10);
        chk("bit0 sec", bus.rd_sec, 1'b1);

        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_en = 1; bus.rd_addr = 4'(i);
            step();
        end
        bus.rd_en = 0;
        $display("back-to-back reads of all %0d words", DEPTH);

        wr(7, 8'h5A); inj(7, 4, 0, 0);
        scrub_active = 1;
        scrub_en = 1;
        n = 0; busy_seen = 0;
        do begin
            @(negedge clk);
            if (scrub_busy) busy_seen = 1;
            n++;
        end while (!scrub_done && n < 2000);
        chk("scrub_done within bound", scrub_done, 1'b1);
        chk("scrub_busy seen", busy_seen, 1'b1);
        apply_sweep();
        $display("scrub sweep done after %0d cycles", n);
        @(negedge clk);
        chk("scrub_done one cycle", scrub_done, 1'b0);
        scrub_en = 0;
        repeat (3) step();
        scrub_active = 0;
        rd(7);
        chk("scrubbed sec", bus.rd_sec, 1'b0);
        chk("scrubbed data", bus.rd_data, 8'h5A);
        rd(5);
        chk("ded left in place", bus.rd_ded, 1'b1);

        inj(7, 4, 0, 0);
        bus.rd_en = 1; bus.rd_addr = 7;
        repeat (65540) step();
        bus.rd_en = 0;
        @(negedge clk);
        $display("65540 SEC reads @7 -> sec_count %04h", sec_count);
        chk("sec_count saturated", sec_count, 16'hFFFF);

        scrub_active = 1;
        scrub_en = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scrub_busy && n < 200);
        chk("scrub_busy before reset", scrub_busy, 1'b1);
        rst = 0; scrub_en = 0;
        @(posedge clk);
        #1;
        rst = 1;
        scrub_active = 0;
        @(negedge clk);
        $display("reset mid-scrub");
        chk("post-reset busy", scrub_busy, 1'b0);
        chk("post-reset sec_count", sec_count, 16'h0);
        chk("post-reset ded_count", ded_count, 16'h0);
        chk("post-reset rd_data", bus.rd_data, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            rd(4'(i));
            chk("post-reset word", bus.rd_data, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
